eq_band_sequencer: RTL and testbench

- Per-band controller for one circular sample queue and its FIR multiply-accumulate (MAC) datapath in the audio equalizer.
- Decimates the codec sample-valid strobe into the queue write strobe.
- Follows the queue's `sequencing` flag and, from it, drives the coefficient-ROM address, accumulator clear/enable, a `done` strobe and sticky error flags.
- Sits between the codec interface, one queue instance, the coefficient ROM and the band MAC. It does not touch sample data.

---
 rtl/eq_band_sequencer_if.sv | 28 ++
 rtl/eq_band_sequencer.sv | 131 +++++++++++++
 tb/tb_eq_band_sequencer.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/eq_band_sequencer_if.sv
// Signal bundle between the band sequencer and its surroundings: codec strobe,
// queue handshake, coefficient-ROM address, MAC controls and error flags.
interface eq_band_sequencer_if #(
    parameter int ADDR_W = 10
);
    logic              vld;
    logic              sequencing;
    logic              clr_err;
    logic              wrt_smpl;
    logic [ADDR_W-1:0] coeff_addr;
    logic              clr_accum;
    logic              accum_en;
    logic              done;
    logic              ovr_err;
    logic              len_err;

    // Side that feeds codec/queue status in and consumes the controls
    modport master (
        output vld, sequencing, clr_err,
        input  wrt_smpl, coeff_addr, clr_accum, accum_en, done, ovr_err, len_err
    );

    // The sequencer itself
    modport slave (
        input  vld, sequencing, clr_err,
        output wrt_smpl, coeff_addr, clr_accum, accum_en, done, ovr_err, len_err
    );
endinterface

// File: rtl/eq_band_sequencer.sv
// Per-band controller for one circular sample queue and its FIR MAC.
// Decimates the codec strobe into queue writes, tracks the queue readout burst
// to drive the coefficient address and accumulator controls, and keeps sticky
// overrun / burst-length error flags. Sample data never passes through here.
module eq_band_sequencer #(
    parameter int TAPS   = 1021,
    parameter int ADDR_W = 10,
    parameter int DECIM  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    eq_band_sequencer_if.slave bus
);

    localparam int                PH_W      = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(DECIM - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(TAPS - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    logic [PH_W-1:0]   phase_q, phase_d;
    logic              wrt_q, wrt_d;
    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              last_hit_q, last_hit_d;
    logic              accum_en_q, accum_en_d;
    logic              ovr_q, ovr_d;
    logic              len_q, len_d;

    logic              dec_write;
    logic              seq_hit;
    logic              len_set;
    logic              start_burst;

    // Decimation: only a strobe arriving at phase 0 becomes a queue write
    always_comb begin
        dec_write = bus.vld && (phase_q == '0);
        phase_d   = phase_q;
        if (bus.vld) begin
            phase_d = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
        end
        wrt_d = dec_write;
    end

    // Burst tracking: address walk with saturation, length checking, flush
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        last_hit_d  = last_hit_q;
        len_set     = 1'b0;
        start_burst = 1'b0;
        seq_hit     = bus.sequencing && (addr_q == ADDR_LAST);
        case (state_q)
            S_IDLE: begin
                addr_d = '0;
                if (bus.sequencing) begin
                    start_burst = 1'b1;
                    state_d     = S_ACCUM;
                    last_hit_d  = seq_hit;
                    addr_d      = seq_hit ? addr_q : addr_q + 1'b1;
                end
            end
            S_ACCUM: begin
                if (bus.sequencing) begin
                    if (seq_hit) begin
                        if (last_hit_q) begin
                            len_set = 1'b1;
                        end
                        last_hit_d = 1'b1;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end else begin
                    state_d = S_FLUSH;
                    if (!last_hit_q) begin
                        len_set = 1'b1;
                    end
                end
            end
            S_FLUSH: begin
                addr_d  = '0;
                state_d = S_IDLE;
            end
            default: begin
                addr_d  = '0;
                state_d = S_IDLE;
            end
        endcase
        accum_en_d = bus.sequencing && (state_q != S_FLUSH);
        ovr_d      = (dec_write && (state_q != S_IDLE)) || (ovr_q && !bus.clr_err);
        len_d      = len_set || (len_q && !bus.clr_err);
    end

    // State and output registers, all cleared by the asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q    <= '0;
            wrt_q      <= 1'b0;
            state_q    <= S_IDLE;
            addr_q     <= '0;
            last_hit_q <= 1'b0;
            accum_en_q <= 1'b0;
            ovr_q      <= 1'b0;
            len_q      <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            wrt_q      <= wrt_d;
            state_q    <= state_d;
            addr_q     <= addr_d;
            last_hit_q <= last_hit_d;
            accum_en_q <= accum_en_d;
            ovr_q      <= ovr_d;
            len_q      <= len_d;
        end
    end

    // clr_accum is combinational from sequencing, so it is gated by rst_n to
    // keep every output low while reset is held
    always_comb begin
        bus.clr_accum  = start_burst && rst_n;
        bus.wrt_smpl   = wrt_q;
        bus.coeff_addr = addr_q;
        bus.accum_en   = accum_en_q;
        bus.done       = (state_q == S_FLUSH);
        bus.ovr_err    = ovr_q;
        bus.len_err    = len_q;
    end

endmodule

// File: tb/tb_eq_band_sequencer.sv
// Self-checking bench for eq_band_sequencer: directed burst scenarios with
// randomized codec strobes, checked against a timeline-based reference model.
module tb_eq_band_sequencer;

    localparam int TAPS   = 1021;
    localparam int ADDR_W = 10;
    localparam int DECIM  = 2;

    logic clk = 1'b0;
    logic rst_n;

    eq_band_sequencer_if #(.ADDR_W(ADDR_W)) bus ();
    eq_band_sequencer_if #(.ADDR_W(ADDR_W)) bus1 ();

    eq_band_sequencer #(.TAPS(TAPS), .ADDR_W(ADDR_W), .DECIM(DECIM)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    eq_band_sequencer #(.TAPS(TAPS), .ADDR_W(ADDR_W), .DECIM(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    // Free-running clock
    always #5 clk = ~clk;

    int passCount  = 0;
    int failCount  = 0;
    int checkTotal = 0;
    int curK       = 0;

    // Reference model state
    int   nVld    = 0;
    logic wrtExp  = 1'b0;
    logic wrt1Exp = 1'b0;
    logic ovrExp  = 1'b0;
    logic lenExp  = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkTotal++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s @k=%0d observed=%0h expected=%0h", tag, curK, obs, exp);
        end
    endtask

    task automatic resetModel();
        nVld    = 0;
        wrtExp  = 1'b0;
        wrt1Exp = 1'b0;
        ovrExp  = 1'b0;
        lenExp  = 1'b0;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " wrt_smpl"},   32'(bus.wrt_smpl),   0);
        checkOutput({tag, " coeff_addr"}, 32'(bus.coeff_addr), 0);
        checkOutput({tag, " clr_accum"},  32'(bus.clr_accum),  0);
        checkOutput({tag, " accum_en"},   32'(bus.accum_en),   0);
        checkOutput({tag, " done"},       32'(bus.done),       0);
        checkOutput({tag, " ovr_err"},    32'(bus.ovr_err),    0);
        checkOutput({tag, " len_err"},    32'(bus.len_err),    0);
        checkOutput({tag, " wrt1"},       32'(bus1.wrt_smpl),  0);
    endtask

    // One burst of L seq-high cycles (L=0: idle only) followed by gap idle cycles.
    // vldMode: 0 none, 1 random, 2 every 10 cycles, 3 at k=5 and k=7.
    // clrAt pulses clr_err at that k; abortAt asserts reset in that cycle.
    task automatic applyStimulus(input int L, input int gap, input int vldMode,
                                 input int clrAt, input int abortAt);
        int last;
        last = (L > 0) ? L + 1 + gap : gap;
        for (int k = 0; k <= last; k++) begin
            logic v;
            logic v1;
            logic clr;
            logic dec;
            logic busy;
            logic lenSet;
            int   expAddr;
            curK = k;
            case (vldMode)
                1:       v = ($urandom_range(0, 5) == 0);
                2:       v = ((k % 10) == 0);
                3:       v = (k == 5) || (k == 7);
                default: v = 1'b0;
            endcase
            v1  = ((k % 2) == 0);
            clr = (k == clrAt);
            bus.sequencing = (k < L);
            bus.vld        = v;
            bus.clr_err    = clr;
            bus1.vld       = v1;

            @(negedge clk);
            if (L > 0 && k <= L + 1) begin
                expAddr = (k < L) ? k : L;
                if (expAddr > TAPS - 1) expAddr = TAPS - 1;
            end else begin
                expAddr = 0;
            end
            checkOutput("coeff_addr", 32'(bus.coeff_addr), 32'(expAddr));
            checkOutput("clr_accum",  32'(bus.clr_accum),  32'(L > 0 && k == 0));
            checkOutput("accum_en",   32'(bus.accum_en),   32'(L > 0 && k >= 1 && k <= L));
            checkOutput("done",       32'(bus.done),       32'(L > 0 && k == L + 1));
            checkOutput("wrt_smpl",   32'(bus.wrt_smpl),   32'(wrtExp));
            checkOutput("ovr_err",    32'(bus.ovr_err),    32'(ovrExp));
            checkOutput("len_err",    32'(bus.len_err),    32'(lenExp));
            checkOutput("wrt1",       32'(bus1.wrt_smpl),  32'(wrt1Exp));

            if (k == abortAt) begin
                #1 rst_n = 1'b0;
                #1 checkAllZero("async reset");
                bus.sequencing = 1'b0;
                bus.vld        = 1'b0;
                bus.clr_err    = 1'b0;
                bus1.vld       = 1'b0;
                resetModel();
                @(posedge clk);
                #1 rst_n = 1'b1;
                return;
            end

            dec    = v && ((nVld % DECIM) == 0);
            busy   = (L > 0) && (k >= 1) && (k <= L + 1);
            lenSet = (L > 0) && (((L < TAPS) && (k == L)) || ((L > TAPS) && (k == TAPS)));
            wrtExp  = dec;
            wrt1Exp = v1;
            if (v) nVld++;
            ovrExp = (dec && busy) || (ovrExp && !clr);
            lenExp = lenSet || (lenExp && !clr);

            @(posedge clk);
            #1;
        end
        bus.sequencing = 1'b0;
        bus.vld        = 1'b0;
        bus.clr_err    = 1'b0;
        bus1.vld       = 1'b0;
    endtask

    // Directed scenario sequence
    initial begin
        rst_n           = 1'b1;
        bus.vld         = 1'b0;
        bus.sequencing  = 1'b0;
        bus.clr_err     = 1'b0;
        bus1.vld        = 1'b0;
        bus1.sequencing = 1'b0;
        bus1.clr_err    = 1'b0;
        #2 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        curK = -1;
        checkAllZero("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        resetModel();

        $display("[TB] decimated writes");
        applyStimulus(0, 40, 2, -1, -1);

        $display("[TB] exact-length burst");
        applyStimulus(TAPS, 4, 0, -1, -1);

        $display("[TB] long burst");
        applyStimulus(TAPS + 4, 4, 1, -1, -1);

        $display("[TB] overrun and clear");
        applyStimulus(TAPS, 4, 3, 20, -1);

        $display("[TB] reset mid-burst");
        applyStimulus(TAPS, 4, 1, -1, 500);

        $display("[TB] clean burst after reset");
        applyStimulus(TAPS, 4, 0, -1, -1);

        $display("[TB] random short bursts");
        for (int i = 0; i < 6; i++) begin
            int len;
            len = $urandom_range(1, 60);
            applyStimulus(len, $urandom_range(2, 12), 1, $urandom_range(0, len + 6), -1);
        end

        $display("[TB] random strobes over full burst");
        applyStimulus(TAPS, 6, 1, $urandom_range(0, TAPS), -1);

        $display("%0d/%0d checks passed", passCount, checkTotal);
        $finish;
    end

endmodule
